// File: rtl/lsu_store_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lsu_store_queue
// Purpose  : In-order LSU store queue: dispatch->commit->drain with a single
//            outstanding memory write and per-byte store-to-load forwarding.
// Options  : LSU_SQ_FWD_EN enables forwarded load data (else overlap stalls)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_store_queue #(
  parameter int SQ_DEPTH = 8,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int ROB_W    = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [ROB_W-1:0]            alloc_rob_idx,
  input  logic [ADDR_W-1:0]           alloc_addr,
  input  logic [1:0]                  alloc_size,
  input  logic [XLEN-1:0]             alloc_data,
  output logic [$clog2(SQ_DEPTH)-1:0] alloc_idx,
  input  logic                        commit_valid,
  input  logic [ROB_W-1:0]            commit_rob_idx,
  input  logic                        flush,
  input  logic                        ld_valid,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [1:0]                  ld_size,
  input  logic [$clog2(SQ_DEPTH):0]   ld_sq_tail,
  output logic                        fwd_hit,
  output logic                        fwd_partial,
  output logic [XLEN-1:0]             fwd_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [XLEN-1:0]             mem_wdata,
  output logic [XLEN/8-1:0]           mem_wstrb,
  input  logic                        mem_resp_valid,
  input  logic                        mem_resp_err,
  output logic                        exc_valid,
  output logic [1:0]                  exc_cause,
  output logic [ROB_W-1:0]            exc_rob_idx,
  output logic                        commit_err,
  output logic [$clog2(SQ_DEPTH):0]   count,
  output logic                        empty
);

  localparam int PW    = $clog2(SQ_DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int SB    = XLEN / 8;
  localparam int OFF_W = $clog2(SB);
  localparam int WA_W  = ADDR_W - OFF_W;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  // Entries keep lane-aligned data/strobe and word address, ready for drain and lookup.
  logic [SQ_DEPTH-1:0] r_valid, r_exc, r_cmt;
  logic [ROB_W-1:0]    r_rob   [SQ_DEPTH];
  logic [WA_W-1:0]     r_waddr [SQ_DEPTH];
  logic [SB-1:0]       r_strb  [SQ_DEPTH];
  logic [XLEN-1:0]     r_data  [SQ_DEPTH];

  logic [PTR_W-1:0] r_head, r_cptr, r_tail;
  logic [1:0]       r_state;
  logic             r_exc_valid, r_commit_err;
  logic [1:0]       r_exc_cause;
  logic [ROB_W-1:0] r_exc_rob;

  logic [PW-1:0]    w_hidx, w_cidx, w_tidx;
  logic             w_full, w_pending, w_alloc_fire, w_commit_fire, w_alloc_mis;
  logic [OFF_W-1:0] w_aoff, w_ld_off;
  logic [7:0]       w_amask8, w_lmask8;
  logic [XLEN-1:0]  w_adm, w_awdata;
  logic [SB-1:0]    w_astrb, w_lstrb, w_cov, w_lcov;
  logic [PTR_W-1:0] w_lim;
  logic [PW-1:0]    w_fidx;
`ifdef LSU_SQ_FWD_EN
  logic [XLEN-1:0]  w_gath, w_lbits;
  logic             w_full_cov;
`endif

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    align_mask = 3'd0;
      2'd1:    align_mask = 3'd1;
      2'd2:    align_mask = 3'd3;
      default: align_mask = 3'd7;
    endcase
  endfunction

  assign w_hidx        = r_head[PW-1:0];
  assign w_cidx        = r_cptr[PW-1:0];
  assign w_tidx        = r_tail[PW-1:0];
  assign w_full        = (r_tail ^ r_head) == PTR_W'(SQ_DEPTH);
  assign w_pending     = (r_head != r_cptr);
  assign w_alloc_fire  = alloc_valid && !w_full && !flush;
  assign w_commit_fire = commit_valid && (r_cptr != r_tail) && (r_rob[w_cidx] == commit_rob_idx);
  assign w_alloc_mis   = ((alloc_addr[2:0] & align_mask(alloc_size)) != 3'd0)
                         || ((alloc_size == 2'd3) && (XLEN == 32));

  assign alloc_ready = !w_full;
  assign alloc_idx   = w_tidx;
  assign count       = r_tail - r_head;
  assign empty       = (r_tail == r_head);
  assign exc_valid   = r_exc_valid;
  assign exc_cause   = r_exc_cause;
  assign exc_rob_idx = r_exc_rob;
  assign commit_err  = r_commit_err;

  assign mem_req_valid = (r_state == c_st_req);
  assign mem_addr      = mem_req_valid ? {r_waddr[w_hidx], {OFF_W{1'b0}}} : '0;
  assign mem_wdata     = mem_req_valid ? r_data[w_hidx] : '0;
  assign mem_wstrb     = mem_req_valid ? r_strb[w_hidx] : '0;

  always_comb begin
    w_aoff   = alloc_addr[OFF_W-1:0];
    w_amask8 = size_mask(alloc_size);
    w_adm    = '0;
    for (int b = 0; b < SB; b++) w_adm[8*b +: 8] = {8{w_amask8[b]}};
    w_astrb  = SB'(w_amask8 << w_aoff);
    w_awdata = (alloc_data & w_adm) << {w_aoff, 3'b000};
  end

  // Oldest-to-youngest scan so later (younger) entries overwrite earlier bytes.
  always_comb begin
    w_ld_off = ld_addr[OFF_W-1:0];
    w_lmask8 = size_mask(ld_size);
    w_lstrb  = SB'(w_lmask8 << w_ld_off);
    w_lim    = ld_sq_tail - r_head;
    w_cov    = '0;
    w_fidx   = '0;
`ifdef LSU_SQ_FWD_EN
    w_gath   = '0;
`endif
    for (int k = 0; k < SQ_DEPTH; k++) begin
      w_fidx = w_hidx + PW'(k);
      if ((PTR_W'(k) < w_lim) && r_valid[w_fidx] && !r_exc[w_fidx]
          && (r_waddr[w_fidx] == ld_addr[ADDR_W-1:OFF_W])) begin
        for (int b = 0; b < SB; b++) begin
          if (r_strb[w_fidx][b]) begin
            w_cov[b] = 1'b1;
`ifdef LSU_SQ_FWD_EN
            w_gath[8*b +: 8] = r_data[w_fidx][8*b +: 8];
`endif
          end
        end
      end
    end
    w_lcov = w_cov & w_lstrb;
`ifdef LSU_SQ_FWD_EN
    w_lbits = '0;
    for (int b = 0; b < SB; b++) w_lbits[8*b +: 8] = {8{w_lcov[b]}};
    w_full_cov  = (w_lcov == w_lstrb) && (w_lstrb != '0);
    fwd_hit     = ld_valid && w_full_cov;
    fwd_partial = ld_valid && (w_lcov != '0) && !w_full_cov;
    fwd_data    = fwd_hit ? ((w_gath & w_lbits) >> {w_ld_off, 3'b000}) : '0;
`else
    fwd_hit     = 1'b0;
    fwd_partial = ld_valid && (w_lcov != '0);
    fwd_data    = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= '0;
      r_exc        <= '0;
      r_cmt        <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_rob[i]   <= '0;
        r_waddr[i] <= '0;
        r_strb[i]  <= '0;
        r_data[i]  <= '0;
      end
      r_head       <= '0;
      r_cptr       <= '0;
      r_tail       <= '0;
      r_state      <= c_st_idle;
      r_exc_valid  <= 1'b0;
      r_exc_cause  <= 2'd0;
      r_exc_rob    <= '0;
      r_commit_err <= 1'b0;
    end else begin
      r_exc_valid  <= 1'b0;
      r_commit_err <= 1'b0;

      if (w_alloc_fire) begin
        r_valid[w_tidx] <= 1'b1;
        r_exc[w_tidx]   <= w_alloc_mis;
        r_cmt[w_tidx]   <= 1'b0;
        r_rob[w_tidx]   <= alloc_rob_idx;
        r_waddr[w_tidx] <= alloc_addr[ADDR_W-1:OFF_W];
        r_strb[w_tidx]  <= w_astrb;
        r_data[w_tidx]  <= w_awdata;
        r_tail          <= r_tail + PTR_W'(1);
      end

      if (w_commit_fire) begin
        r_cmt[w_cidx] <= 1'b1;
        r_cptr        <= r_cptr + PTR_W'(1);
      end else if (commit_valid) begin
        r_commit_err  <= 1'b1;
      end

      // A same-cycle commit survives the flush; everything younger is discarded.
      if (flush) begin
        for (int i = 0; i < SQ_DEPTH; i++)
          if (!r_cmt[i] && !(w_commit_fire && (PW'(i) == w_cidx))) r_valid[i] <= 1'b0;
        r_tail <= w_commit_fire ? r_cptr + PTR_W'(1) : r_cptr;
      end

      case (r_state)
        c_st_idle: begin
          if (w_pending) begin
            if (r_exc[w_hidx]) begin
              r_valid[w_hidx] <= 1'b0;
              r_head          <= r_head + PTR_W'(1);
              r_exc_valid     <= 1'b1;
              r_exc_cause     <= 2'd1;
              r_exc_rob       <= r_rob[w_hidx];
            end else begin
              r_state <= c_st_req;
            end
          end
        end
        c_st_req: if (mem_req_ready) r_state <= c_st_resp;
        c_st_resp: begin
          if (mem_resp_valid) begin
            r_valid[w_hidx] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
            r_state         <= c_st_idle;
            if (mem_resp_err) begin
              r_exc_valid <= 1'b1;
              r_exc_cause <= 2'd2;
              r_exc_rob   <= r_rob[w_hidx];
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu_store_queue
// Purpose  : Self-checking bench for lsu_store_queue with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_store_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_ready;
  logic [5:0]  alloc_rob_idx;
  logic [31:0] alloc_addr;
  logic [1:0]  alloc_size;
  logic [31:0] alloc_data;
  logic [2:0]  alloc_idx;
  logic        commit_valid;
  logic [5:0]  commit_rob_idx;
  logic        flush;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic [3:0]  ld_sq_tail;
  logic        fwd_hit, fwd_partial;
  logic [31:0] fwd_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic [5:0]  exc_rob_idx;
  logic        commit_err;
  logic [3:0]  count;
  logic        empty;

  always #5 clk = ~clk;

  lsu_store_queue #(.SQ_DEPTH(8), .XLEN(32), .ADDR_W(32), .ROB_W(6)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
    .alloc_addr(alloc_addr), .alloc_size(alloc_size), .alloc_data(alloc_data), .alloc_idx(alloc_idx),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_sq_tail(ld_sq_tail),
    .fwd_hit(fwd_hit), .fwd_partial(fwd_partial), .fwd_data(fwd_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_rob_idx(exc_rob_idx),
    .commit_err(commit_err), .count(count), .empty(empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] m_tail, m_cptr;
  wr_t  sb_q[$];

  function automatic wr_t model_wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    wr_t w;
    int  off, n;
    off    = int'(a[1:0]);
    n      = 1 << s;
    w.addr = {a[31:2], 2'b00};
    w.data = '0;
    w.strb = '0;
    for (int b = 0; b < n; b++) begin
      if (off + b < 4) begin
        w.strb[off+b]          = 1'b1;
        w.data[8*(off+b) +: 8] = d[8*b +: 8];
      end
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [5:0] rob, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    alloc_valid = 1'b1; alloc_rob_idx = rob; alloc_addr = a; alloc_size = s; alloc_data = d;
    tick;
    alloc_valid = 1'b0;
    m_tail = m_tail + 4'd1;
  endtask

  task automatic do_commit(input logic [5:0] rob, input bit accept);
    commit_valid = 1'b1; commit_rob_idx = rob;
    tick;
    commit_valid = 1'b0;
    if (accept) m_cptr = m_cptr + 4'd1;
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    m_tail = m_cptr;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [1:0] s, input logic [3:0] t);
    ld_valid = 1'b1; ld_addr = a; ld_size = s; ld_sq_tail = t;
    #1;
  endtask

  // Accepts one write request within a cycle budget, then responds after dly cycles.
  task automatic mem_drain(input int dly, input logic err, output wr_t got, output bit ok);
    ok = 1'b0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin ok = 1'b1; break; end
      tick;
    end
    got.addr = mem_addr; got.data = mem_wdata; got.strb = mem_wstrb;
    tick;
    mem_req_ready = 1'b0;
    if (ok) begin
      repeat (dly) tick;
      mem_resp_valid = 1'b1; mem_resp_err = err;
      tick;
      mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_tail = '0; m_cptr = '0;
    tick;
    n_tests++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if ({mem_req_valid, exc_valid, commit_err, fwd_hit, fwd_partial} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {mem_req_valid, exc_valid, commit_err, fwd_hit, fwd_partial}); end
    n_tests++; if ({alloc_idx, mem_wstrb, exc_cause} !== 9'b0) begin
      n_fail++; $display("FAIL reset_fields: got %h expected 0", {alloc_idx, mem_wstrb, exc_cause}); end
  endtask

  task automatic test_drain_word;
    wr_t got, exp; bit ok;
    do_alloc(6'd1, 32'h4, 2'd2, 32'hAABBCCDD);
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL drain_count_pre: got %0d expected 1", count); end
    do_commit(6'd1, 1'b1);
    sb_q.push_back(model_wr(32'h4, 2'd2, 32'hAABBCCDD));
    mem_drain(2, 1'b0, got, ok);
    exp = sb_q.pop_front();
    n_tests++; if (!ok) begin n_fail++; $display("FAIL drain_req_timeout: got none expected request"); end
    n_tests++; if ({got.addr, got.data, got.strb} !== {exp.addr, exp.data, exp.strb}) begin
      n_fail++; $display("FAIL drain_word: got %h/%h/%h expected %h/%h/%h", got.addr, got.data, got.strb, exp.addr, exp.data, exp.strb); end
    n_tests++; if (count !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_count_post: got %0d/%b expected 0/1", count, empty); end
  endtask

  task automatic test_fwd_partial;
    wr_t got, exp; bit ok;
    do_alloc(6'd2, 32'h6, 2'd0, 32'h11);
    set_load(32'h4, 2'd2, m_tail);
    n_tests++; if ({fwd_hit, fwd_partial} !== 2'b01) begin n_fail++; $display("FAIL fwd_word_over_byte: got %b expected 01", {fwd_hit, fwd_partial}); end
    set_load(32'h6, 2'd0, m_tail);
`ifdef LSU_SQ_FWD_EN
    n_tests++; if ({fwd_hit, fwd_partial, fwd_data} !== {2'b10, 32'h11}) begin
      n_fail++; $display("FAIL fwd_byte_hit: got %b%b/%h expected 10/00000011", fwd_hit, fwd_partial, fwd_data); end
`else
    n_tests++; if ({fwd_hit, fwd_partial, fwd_data} !== {2'b01, 32'h0}) begin
      n_fail++; $display("FAIL fwd_byte_stall: got %b%b/%h expected 01/00000000", fwd_hit, fwd_partial, fwd_data); end
`endif
    set_load(32'h6, 2'd0, m_tail - 4'd1);
    n_tests++; if ({fwd_hit, fwd_partial} !== 2'b00) begin n_fail++; $display("FAIL fwd_older_load: got %b expected 00", {fwd_hit, fwd_partial}); end
    tick;
    set_load(32'h5, 2'd0, m_tail);
    n_tests++; if ({fwd_hit, fwd_partial} !== 2'b00) begin n_fail++; $display("FAIL fwd_no_overlap: got %b expected 00", {fwd_hit, fwd_partial}); end
    ld_valid = 1'b0; ld_addr = 32'h6; #1;
    n_tests++; if ({fwd_hit, fwd_partial, fwd_data} !== 34'b0) begin n_fail++; $display("FAIL fwd_ld_invalid: got %b%b/%h expected 0", fwd_hit, fwd_partial, fwd_data); end
    do_commit(6'd2, 1'b1);
    sb_q.push_back(model_wr(32'h6, 2'd0, 32'h11));
    mem_drain(1, 1'b0, got, ok);
    exp = sb_q.pop_front();
    n_tests++; if (!ok || {got.addr, got.data, got.strb} !== {exp.addr, exp.data, exp.strb}) begin
      n_fail++; $display("FAIL drain_byte: got %h/%h/%h expected %h/%h/%h", got.addr, got.data, got.strb, exp.addr, exp.data, exp.strb); end
  endtask

  task automatic test_fwd_youngest;
    wr_t got, exp; bit ok;
    logic [3:0] t1;
    do_alloc(6'd3, 32'h8, 2'd2, 32'h1);
    t1 = m_tail;
    do_alloc(6'd4, 32'h8, 2'd2, 32'h2);
    set_load(32'h8, 2'd2, m_tail);
`ifdef LSU_SQ_FWD_EN
    n_tests++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h2}) begin n_fail++; $display("FAIL fwd_youngest: got %b/%h expected 1/00000002", fwd_hit, fwd_data); end
    set_load(32'h8, 2'd2, t1);
    n_tests++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h1}) begin n_fail++; $display("FAIL fwd_snapshot: got %b/%h expected 1/00000001", fwd_hit, fwd_data); end
`else
    n_tests++; if ({fwd_hit, fwd_partial} !== 2'b01) begin n_fail++; $display("FAIL fwd_youngest_stall: got %b expected 01", {fwd_hit, fwd_partial}); end
    set_load(32'h8, 2'd2, t1);
    n_tests++; if ({fwd_hit, fwd_partial} !== 2'b01) begin n_fail++; $display("FAIL fwd_snapshot_stall: got %b expected 01", {fwd_hit, fwd_partial}); end
`endif
    ld_valid = 1'b0;
    do_commit(6'd3, 1'b1); sb_q.push_back(model_wr(32'h8, 2'd2, 32'h1));
    do_commit(6'd4, 1'b1); sb_q.push_back(model_wr(32'h8, 2'd2, 32'h2));
    for (int i = 0; i < 2; i++) begin
      mem_drain(0, 1'b0, got, ok);
      exp = sb_q.pop_front();
      n_tests++; if (!ok || {got.addr, got.data, got.strb} !== {exp.addr, exp.data, exp.strb}) begin
        n_fail++; $display("FAIL drain_pair%0d: got %h/%h/%h expected %h/%h/%h", i, got.addr, got.data, got.strb, exp.addr, exp.data, exp.strb); end
    end
  endtask

  task automatic test_full_flush;
    wr_t got, exp; bit ok;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (alloc_idx !== m_tail[2:0]) begin n_fail++; $display("FAIL fill_idx%0d: got %0d expected %0d", i, alloc_idx, m_tail[2:0]); end
      do_alloc(6'(10 + i), 32'h100 + 32'(4 * i), 2'd2, 32'(i + 1));
    end
    n_tests++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin n_fail++; $display("FAIL full: got %b/%0d expected 0/8", alloc_ready, count); end
    alloc_valid = 1'b1; alloc_rob_idx = 6'd63; alloc_addr = 32'h500; alloc_size = 2'd2; alloc_data = 32'hFFFF;
    tick;
    alloc_valid = 1'b0;
    n_tests++; if (count !== 4'd8 || alloc_idx !== m_tail[2:0]) begin n_fail++; $display("FAIL alloc_when_full: got %0d/%0d expected 8/%0d", count, alloc_idx, m_tail[2:0]); end
    for (int i = 0; i < 3; i++) begin
      do_commit(6'(10 + i), 1'b1);
      sb_q.push_back(model_wr(32'h100 + 32'(4 * i), 2'd2, 32'(i + 1)));
    end
    do_flush;
    n_tests++; if (count !== 4'd3 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_count: got %0d/%b expected 3/1", count, alloc_ready); end
    for (int i = 0; i < 3; i++) begin
      mem_drain(1, 1'b0, got, ok);
      exp = sb_q.pop_front();
      n_tests++; if (!ok || {got.addr, got.data, got.strb} !== {exp.addr, exp.data, exp.strb}) begin
        n_fail++; $display("FAIL drain_committed%0d: got %h/%h expected %h/%h", i, got.addr, got.data, exp.addr, exp.data); end
    end
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) do_alloc(6'(20 + i), 32'h200 + 32'(4 * i), 2'd2, 32'h0);
      n_tests++; if (count !== 4'd8 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL refill%0d_full: got %0d/%b expected 8/0", p, count, alloc_ready); end
      do_flush;
      n_tests++; if (count !== 4'd0 || alloc_idx !== m_tail[2:0]) begin n_fail++; $display("FAIL refill%0d_flush: got %0d/%0d expected 0/%0d", p, count, alloc_idx, m_tail[2:0]); end
    end
    alloc_valid = 1'b1; alloc_rob_idx = 6'd39; alloc_addr = 32'h400; alloc_size = 2'd2; flush = 1'b1;
    tick;
    alloc_valid = 1'b0; flush = 1'b0;
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_beats_alloc: got %0d expected 0", count); end
    do_alloc(6'd40, 32'h300, 2'd2, 32'hDEAD);
    do_alloc(6'd41, 32'h304, 2'd2, 32'hBEEF);
    commit_valid = 1'b1; commit_rob_idx = 6'd40; flush = 1'b1;
    tick;
    commit_valid = 1'b0; flush = 1'b0;
    m_cptr = m_cptr + 4'd1; m_tail = m_cptr;
    sb_q.push_back(model_wr(32'h300, 2'd2, 32'hDEAD));
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL commit_then_flush: got %0d expected 1", count); end
    mem_drain(0, 1'b0, got, ok);
    exp = sb_q.pop_front();
    n_tests++; if (!ok || got.data !== exp.data || empty !== 1'b1) begin n_fail++; $display("FAIL commit_flush_drain: got %h/%b expected %h/1", got.data, empty, exp.data); end
  endtask

  task automatic test_exceptions;
    wr_t got, exp; bit ok, seen_req;
    do_alloc(6'd30, 32'h3, 2'd1, 32'hBEEF);
    set_load(32'h3, 2'd0, m_tail);
    n_tests++; if ({fwd_hit, fwd_partial} !== 2'b00) begin n_fail++; $display("FAIL fwd_skips_misaligned: got %b expected 00", {fwd_hit, fwd_partial}); end
    ld_valid = 1'b0;
    do_commit(6'd30, 1'b1);
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) seen_req = 1'b1;
      if (exc_valid) break;
      tick;
    end
    n_tests++; if ({exc_valid, exc_cause, exc_rob_idx, seen_req} !== {1'b1, 2'd1, 6'd30, 1'b0}) begin
      n_fail++; $display("FAIL misaligned_exc: got %b/%0d/%0d/req%b expected 1/1/30/req0", exc_valid, exc_cause, exc_rob_idx, seen_req); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL misaligned_pop: got %0d expected 0", count); end
    do_alloc(6'd31, 32'h20, 2'd2, 32'h55);
    do_commit(6'd31, 1'b1);
    sb_q.push_back(model_wr(32'h20, 2'd2, 32'h55));
    mem_drain(1, 1'b1, got, ok);
    exp = sb_q.pop_front();
    n_tests++; if (!ok || {got.addr, got.data, got.strb} !== {exp.addr, exp.data, exp.strb}) begin
      n_fail++; $display("FAIL err_store_req: got %h/%h/%h expected %h/%h/%h", got.addr, got.data, got.strb, exp.addr, exp.data, exp.strb); end
    n_tests++; if ({exc_valid, exc_cause, exc_rob_idx} !== {1'b1, 2'd2, 6'd31} || count !== 4'd0) begin
      n_fail++; $display("FAIL mem_err_exc: got %b/%0d/%0d cnt %0d expected 1/2/31 cnt 0", exc_valid, exc_cause, exc_rob_idx, count); end
    tick;
    n_tests++; if (exc_valid !== 1'b0) begin n_fail++; $display("FAIL exc_pulse_width: got %b expected 0", exc_valid); end
  endtask

  task automatic test_commit_err;
    wr_t got, exp; bit ok, seen_req;
    do_alloc(6'd42, 32'h30, 2'd2, 32'h7);
    do_commit(6'd43, 1'b0);
    n_tests++; if (commit_err !== 1'b1) begin n_fail++; $display("FAIL commit_mismatch: got %b expected 1", commit_err); end
    seen_req = 1'b0;
    for (int i = 0; i < 4; i++) begin tick; if (mem_req_valid) seen_req = 1'b1; end
    n_tests++; if ({commit_err, seen_req} !== 2'b00 || count !== 4'd1) begin
      n_fail++; $display("FAIL commit_ptr_held: got err%b req%b cnt %0d expected err0 req0 cnt 1", commit_err, seen_req, count); end
    do_commit(6'd42, 1'b1);
    sb_q.push_back(model_wr(32'h30, 2'd2, 32'h7));
    n_tests++; if (commit_err !== 1'b0) begin n_fail++; $display("FAIL commit_good: got %b expected 0", commit_err); end
    do_commit(6'd42, 1'b0);
    n_tests++; if (commit_err !== 1'b1) begin n_fail++; $display("FAIL commit_nothing: got %b expected 1", commit_err); end
    mem_drain(0, 1'b0, got, ok);
    exp = sb_q.pop_front();
    n_tests++; if (!ok || got.data !== exp.data || got.addr !== exp.addr) begin n_fail++; $display("FAIL commit_err_drain: got %h@%h expected %h@%h", got.data, got.addr, exp.data, exp.addr); end
  endtask

  task automatic test_reset_mid_drain;
    bit seen_req;
    do_alloc(6'd50, 32'h40, 2'd2, 32'h9);
    do_commit(6'd50, 1'b1);
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) begin seen_req = 1'b1; break; end
      tick;
    end
    n_tests++; if (seen_req !== 1'b1) begin n_fail++; $display("FAIL mid_drain_req: got %b expected 1", seen_req); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if ({mem_req_valid, count, empty} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_drain: got req%b cnt %0d empty %b expected req0 cnt 0 empty 1", mem_req_valid, count, empty); end
    tick;
    reset = 1'b0;
    m_tail = '0; m_cptr = '0; sb_q.delete();
    mem_resp_valid = 1'b1;
    tick;
    mem_resp_valid = 1'b0;
    tick;
    n_tests++; if ({exc_valid, mem_req_valid, count, alloc_idx} !== 9'b0) begin
      n_fail++; $display("FAIL stale_resp_ignored: got exc%b req%b cnt %0d idx %0d expected all 0", exc_valid, mem_req_valid, count, alloc_idx); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    alloc_valid = 1'b0; alloc_rob_idx = '0; alloc_addr = '0; alloc_size = '0; alloc_data = '0;
    commit_valid = 1'b0; commit_rob_idx = '0; flush = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_sq_tail = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    m_tail = '0; m_cptr = '0;
    test_reset;
    test_drain_word;
    test_fwd_partial;
    test_fwd_youngest;
    test_full_flush;
    test_exceptions;
    test_commit_err;
    test_reset_mid_drain;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_store_queue.md
Name: lsu_store_queue

Overview:
- Parametrised store queue for the next-generation LSU.
- Holds stores in program order from dispatch to commit, then drains committed stores in order to memory over a valid/ready request channel with a single outstanding write.
- Adds features the first-generation LSU lacks: byte/half/word/dword stores with write strobes, per-byte store-to-load forwarding with partial-overlap detection, flush of uncommitted entries, and precise misalignment and memory-error reporting.

Parameters:
SQ_DEPTH, 8, number of entries (power of 2, >=2)
XLEN, 32, data width (32 or 64); strobe width XLEN/8
ADDR_W, 32, address width
ROB_W, 6, ROB index width

Ports:
clk  in  1  clock
reset  in  1  reset
alloc_valid  in  1  allocate store at tail
alloc_ready  out  1  = !full
alloc_rob_idx  in  ROB_W  ROB index of store
alloc_addr  in  ADDR_W  effective address
alloc_size  in  2  0=B 1=H 2=W 3=D (D legal only when XLEN=64)
alloc_data  in  XLEN  store data, right-aligned
alloc_idx  out  $clog2(SQ_DEPTH)  entry index granted (tail pointer)
commit_valid  in  1  commit oldest uncommitted entry
commit_rob_idx  in  ROB_W  expected ROB index
flush  in  1  discard all uncommitted entries
ld_valid  in  1  forwarding lookup
ld_addr  in  ADDR_W  load address
ld_size  in  2  load size
ld_sq_tail  in  $clog2(SQ_DEPTH)+1  tail snapshot at load dispatch (wrap bit in MSB)
fwd_hit  out  1  all load bytes supplied by older stores
fwd_partial  out  1  some but not all bytes covered; load must stall
fwd_data  out  XLEN  forwarded data, right-aligned, zero-extended
mem_req_valid  out  1  write request
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  alloc_addr with low log2(XLEN/8) bits cleared
mem_wdata  out  XLEN  data shifted to byte lanes
mem_wstrb  out  XLEN/8  byte enables
mem_resp_valid  in  1  write completed
mem_resp_err  in  1  write failed (qualified by resp_valid)
exc_valid  out  1  one-cycle pulse: misaligned or memory-error store
exc_cause  out  2  1=misaligned 2=mem_error
exc_rob_idx  out  ROB_W  faulting store
commit_err  out  1  pulse: commit_rob_idx mismatch or nothing to commit
count  out  $clog2(SQ_DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset values: all entries invalid; pointers 0; FSM IDLE; every output 0 except alloc_ready=1 and empty=1.
- Pointers: head, commit_ptr and tail are $clog2(SQ_DEPTH)+1 bits wide, with the MSB as wrap bit.
  - full = (tail^head)==SQ_DEPTH.
  - count = tail-head.
- Allocation: on alloc_valid && alloc_ready, the entry is written at the clock edge. It is visible to forwarding from the next cycle. tail increments.
  - alloc_valid while full is ignored; no state change.
- Misalignment: addr not a multiple of (1<<size), or size=3 when XLEN=32. The entry is stored with exc=1 and is excluded from forwarding.
- Commit: commit_valid with commit_ptr!=tail and entry.rob_idx==commit_rob_idx sets committed and increments commit_ptr. Otherwise commit_err pulses next cycle and there is no state change.
- Flush: sets tail=commit_ptr next cycle. Committed entries and any in-flight write are unaffected.
  - If flush and alloc occur in the same cycle, flush wins and the alloc is dropped.
  - If flush and commit occur in the same cycle, the commit is applied first, then the flush.
- Drain FSM:
  - IDLE: if head!=commit_ptr and the head entry has exc, pop it and pulse exc_valid (cause 1) next cycle with no memory access. Else if head!=commit_ptr, go to REQ.
  - REQ: mem_req_valid=1, with addr/wdata/wstrb held stable from the head entry. On mem_req_ready, go to RESP.
  - RESP: on mem_resp_valid, pop head and go to IDLE. If mem_resp_err, pulse exc_valid with cause 2 and the head's rob_idx.
  - Throughput is at most 1 store per 3 cycles.
- Lanes: off = addr[log2(XLEN/8)-1:0].
  - wstrb = ((1<<(1<<size))-1)<<off.
  - wdata = data<<(8*off).
- Forwarding (combinational):
  - Searched entries: valid, non-exc, from head up to ld_sq_tail-1, same word address as the load. Committed and in-flight entries are included.
  - Each requested byte takes the youngest covering entry.
  - fwd_hit=all bytes covered; fwd_partial=some but not all; both 0 if none.
  - fwd_data is valid only with fwd_hit.
  - All outputs are 0 when ld_valid=0.
- Simultaneous alloc and pop while full: alloc_ready is still 0, so no bypass.
- Reset mid-drain: the request is dropped immediately (mem_req_valid=0). A later mem_resp_valid is ignored in IDLE.

Optional Feature:
- LSU_SQ_FWD_EN defined: forwarding operates as described above.
- Undefined: fwd_hit=0 and fwd_data=0. fwd_partial=1 whenever any searched entry overlaps any load byte, forcing the load to wait until the store drains.

Test Plan:
- SW 0xAABBCCDD@0x4, commit, mem_req_ready=1, resp after 2 cycles -> mem_addr=0x4, wstrb=0xF, wdata=0xAABBCCDD; count 1->0; empty=1.
- SB 0x11@0x6, then load W@0x4 with ld_sq_tail after the SB -> fwd_partial=1, fwd_hit=0. Load B@0x6 -> fwd_hit=1, fwd_data=0x11. Drained: wstrb=0x4, wdata=0x00110000.
- SW 0x1@0x8 then SW 0x2@0x8, load W@0x8 -> fwd_data=0x2 (youngest). With ld_sq_tail taken before the second store -> 0x1.
- Fill 8 stores -> alloc_ready=0, 9th alloc ignored; commit 3, flush -> count=3 next cycle; tail wraps correctly over 2 refill passes.
- SH@0x3 -> after commit: exc_valid, cause=1, correct rob_idx, no mem_req. Store with mem_resp_err=1 -> cause=2, entry popped.
- commit_rob_idx mismatch -> commit_err pulse, commit_ptr unchanged. Reset asserted during REQ -> mem_req_valid=0 that cycle, count=0.
